// File: rtl/core_pkg.sv
// Shared definitions for the multi-threaded PC generator: run-state encoding
// and a small ring-distance helper used by the round-robin arbiter.
package core_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } run_state_e;

  // Number of steps forward from 'from_idx' to reach 'to_idx' on a ring of
  // size n. Arguments must lie in [0, 2n-1] for the result to be valid.
  function automatic int ring_dist(input int from_idx, input int to_idx, input int n);
    return (to_idx - from_idx + 2 * n) % n;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: returns the first requester strictly
// after 'last' (wrapping), plus a flag saying whether anyone requested.
module rr_arbiter
  import core_pkg::*;
#(
  parameter int NUM_THREADS = 4,
  parameter int TID_W       = (NUM_THREADS > 1) ? $clog2(NUM_THREADS) : 1
) (
  input  logic [NUM_THREADS-1:0] req,
  input  logic [TID_W-1:0]       last,
  output logic [TID_W-1:0]       grant,
  output logic                   any
);

  logic [31:0] last_ext;
  assign last_ext = 32'(last);

  always_comb begin
    int                   best_d;
    int                   best_k;
    int                   d;
    logic [NUM_THREADS-1:0] req_sh;
    best_d = NUM_THREADS;
    best_k = 0;
    d      = 0;
    req_sh = '0;
    for (int k = 0; k < NUM_THREADS; k++) begin
      req_sh = req >> k;
      d      = ring_dist(int'(last_ext) + 1, k, NUM_THREADS);
      if (req_sh[0] && (d < best_d)) begin
        best_d = d;
        best_k = k;
      end
    end
    grant = TID_W'(best_k);
    any   = |req;
  end

endmodule

// File: rtl/pc_gen_mt.sv
// Multi-threaded fetch PC generator: round-robin issue of per-thread PCs with
// stall, per-thread enable and redirect support; one cycle issue latency.
module pc_gen_mt
  import core_pkg::*;
#(
  parameter int               XLEN        = 32,
  parameter int               NUM_THREADS = 4,
  parameter int               TID_W       = (NUM_THREADS > 1) ? $clog2(NUM_THREADS) : 1,
  parameter logic [XLEN-1:0]  RESET_VEC   = '0,
  parameter int               INST_BYTES  = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   start_i,
  input  logic                   stall_i,
  input  logic [NUM_THREADS-1:0] thread_en_i,
  input  logic                   redirect_valid_i,
  input  logic [TID_W-1:0]       redirect_tid_i,
  input  logic [XLEN-1:0]        redirect_pc_i,
  output logic [XLEN-1:0]        pc_o,
  output logic [TID_W-1:0]       tid_o,
  output logic                   valid_o
);

  localparam logic [TID_W-1:0] LAST_INIT = TID_W'(NUM_THREADS - 1);
  localparam logic [XLEN-1:0]  INC       = XLEN'(INST_BYTES);
  localparam logic [XLEN-1:0]  ALIGN_MSK = ~(XLEN'(INST_BYTES - 1));

  // Redirect targets are forced onto an instruction boundary.
  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
    return pc & ALIGN_MSK;
  endfunction

  run_state_e       state;
  logic [XLEN-1:0]  pc_tbl [NUM_THREADS];
  logic [TID_W-1:0] rr_last;
  logic [TID_W-1:0] sel;
  logic             sel_any;
  logic [31:0]      rtid_ext;
  logic             redir_ok;

  rr_arbiter #(
    .NUM_THREADS (NUM_THREADS),
    .TID_W       (TID_W)
  ) u_rr (
    .req   (thread_en_i),
    .last  (rr_last),
    .grant (sel),
    .any   (sel_any)
  );

  assign rtid_ext = 32'(redirect_tid_i);
  assign redir_ok = redirect_valid_i && (rtid_ext < 32'(NUM_THREADS));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= ST_IDLE;
      rr_last <= LAST_INIT;
      pc_o    <= '0;
      tid_o   <= '0;
      valid_o <= 1'b0;
      for (int t = 0; t < NUM_THREADS; t++) pc_tbl[t] <= RESET_VEC;
    end else if (!start_i || (state == ST_IDLE)) begin
      // IDLE (or being forced there): PCs and pointer sit at their start values.
      state   <= start_i ? ST_RUN : ST_IDLE;
      rr_last <= LAST_INIT;
      valid_o <= 1'b0;
      for (int t = 0; t < NUM_THREADS; t++) pc_tbl[t] <= RESET_VEC;
    end else begin
      if (!stall_i) begin
        if (sel_any) begin
          pc_o        <= pc_tbl[sel];
          tid_o       <= sel;
          valid_o     <= 1'b1;
          pc_tbl[sel] <= pc_tbl[sel] + INC;
          rr_last     <= sel;
        end else begin
          valid_o <= 1'b0;
        end
      end
      // Placed last so a same-cycle redirect wins over the increment above.
      if (redir_ok) pc_tbl[redirect_tid_i] <= align_pc(redirect_pc_i);
    end
  end

endmodule

// File: doc/pc_gen_mt.md
PC_GEN_MT -- requirements
Module: pc_gen_mt

Interface
REQ-001 Parameter XLEN, default 32, is the PC width in bits.
REQ-002 Parameter NUM_THREADS, default 4, is the number of hardware threads; legal range 1..16.
REQ-003 Parameter TID_W, default $clog2(NUM_THREADS) with a minimum of 1, is the thread-ID width.
REQ-004 Parameter RESET_VEC, default 0, is the start PC of every thread.
REQ-005 Parameter INST_BYTES, default 4, is the sequential increment; it is a power of two.
REQ-006 The block SHALL have one clock; reset is synchronous and active-high.
REQ-007 Ports, in this order (name, direction, width, meaning):
- clk_i, in, 1, clock, rising edge.
- rst_i, in, 1, synchronous active-high reset.
- start_i, in, 1, run enable; low forces IDLE.
- stall_i, in, 1, freezes issue and PC advance.
- thread_en_i, in, NUM_THREADS, per-thread issue enable.
- redirect_valid_i, in, 1, redirect request.
- redirect_tid_i, in, TID_W, thread being redirected.
- redirect_pc_i, in, XLEN, redirect target.
- pc_o, out, XLEN, issued PC.
- tid_o, out, TID_W, thread of the issued PC.
- valid_o, out, 1, pc_o/tid_o are a valid issue.

Function
REQ-008 Each thread SHALL hold one XLEN-bit PC register, plus a TID_W-bit round-robin pointer rr_last.
REQ-009 State IDLE SHALL move to RUN on start_i=1; RUN SHALL move to IDLE on start_i=0.
REQ-010 In IDLE, all thread PCs SHALL be loaded with RESET_VEC, rr_last with NUM_THREADS-1, and valid_o driven to 0.
REQ-011 In RUN with stall_i=0, the selected thread SHALL be the first enabled thread searching from rr_last+1 upward, modulo NUM_THREADS.
REQ-012 On a clock edge with a thread selected, the block SHALL register pc_o=PC[sel], tid_o=sel and valid_o=1; PC[sel] SHALL become PC[sel]+INST_BYTES, and rr_last SHALL become sel (1-cycle latency).
REQ-013 If no thread is enabled, valid_o SHALL register 0 and every PC and rr_last SHALL hold.
REQ-014 With stall_i=1 in RUN, pc_o, tid_o, valid_o, rr_last and the non-redirected PCs SHALL hold.
REQ-015 PC addition SHALL wrap modulo 2^XLEN.
REQ-016 A redirect SHALL be accepted in RUN, whether stalled or not, and load PC[redirect_tid_i] with redirect_pc_i with the low log2(INST_BYTES) bits cleared.
REQ-017 If the redirected thread is also selected in the same cycle, the issue SHALL use the old PC, and the redirect SHALL take priority over the +INST_BYTES update.
REQ-018 Redirects are ignored in IDLE, and when redirect_tid_i >= NUM_THREADS.
REQ-019 Clearing a thread_en_i bit SHALL take effect on the next selection and SHALL NOT alter that thread's PC.
REQ-020 start_i=0 SHALL override stall_i and redirect_valid_i.

Reset
REQ-021 rst_i=1 SHALL force IDLE, all PCs to RESET_VEC, rr_last to NUM_THREADS-1, pc_o to 0, tid_o to 0 and valid_o to 0, with priority over all other inputs.
REQ-022 Reset asserted mid-RUN SHALL discard pending redirects and in-flight issue with no residual state.

Structure
REQ-023 The state encoding (IDLE, RUN) SHALL live in a shared package, core_pkg.
REQ-024 The round-robin selection SHALL be a sub-module, rr_arbiter, parametrised by NUM_THREADS.
REQ-025 The sub-module SHALL take a request vector and a last-grant index, and return a combinational grant index and an any-grant flag.

Verification
REQ-026 Reset with start_i=1 and all thread_en_i set (NUM_THREADS=4) -> valid_o=1 from cycle 1 with tid sequence 0,1,2,3,0 and pc 0,0,0,0,4.
REQ-027 thread_en_i=4'b1010 -> tid_o alternates 1,3,1,3, and each thread's PC advances by 4 per issue of that thread.
REQ-028 Redirect tid 2 to 0x1003 in the same cycle thread 2 issues pc 0x8 -> that issue shows 0x8, and thread 2's next issue shows 0x1000.
REQ-029 stall_i=1 for 3 cycles with a redirect of tid 0 to 0x40 during the stall -> outputs frozen during the stall, and thread 0's next issue shows 0x40.
REQ-030 Thread PC set to 0xFFFFFFFC by redirect, then issued -> that issue shows 0xFFFFFFFC, and the thread's next issue shows 0x0.
REQ-031 start_i dropped mid-run, then rst_i pulsed during RUN -> valid_o=0 on the next edge, all PCs RESET_VEC, and tid sequence restarts at 0.
